seg_scan_decoder: RTL and testbench

Reader side of the multiplexed seven-segment display bus in the keyboard/display path. Samples the time-multiplexed active-low segment lines and active-low digit-select (anode) lines, waits for each pattern to settle, and decodes it back to a hex nibble per digit position. Used as an on-chip loopback monitor of the display driver and as the bench-visible check of what the panel is showing.

---
 rtl/seg_scan_pkg.sv | 26 ++
 rtl/seg7_pattern_lut.sv | 35 +++
 rtl/seg_scan_decoder.sv | 126 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan reader: active-low glyph table,
// blank pattern and FSM state encoding.
package seg_scan_pkg;

  typedef enum logic [1:0] {SETTLE, COMMIT, HOLD} state_t;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  localparam logic [6:0] PAT_0 = 7'h40;
  localparam logic [6:0] PAT_1 = 7'h79;
  localparam logic [6:0] PAT_2 = 7'h24;
  localparam logic [6:0] PAT_3 = 7'h30;
  localparam logic [6:0] PAT_4 = 7'h19;
  localparam logic [6:0] PAT_5 = 7'h12;
  localparam logic [6:0] PAT_6 = 7'h02;
  localparam logic [6:0] PAT_7 = 7'h78;
  localparam logic [6:0] PAT_8 = 7'h00;
  localparam logic [6:0] PAT_9 = 7'h18;
  localparam logic [6:0] PAT_A = 7'h08;
  localparam logic [6:0] PAT_B = 7'h03;
  localparam logic [6:0] PAT_C = 7'h46;
  localparam logic [6:0] PAT_D = 7'h21;
  localparam logic [6:0] PAT_E = 7'h06;
  localparam logic [6:0] PAT_F = 7'h0E;

endpackage

// File: rtl/seg7_pattern_lut.sv
// Reverse glyph lookup: active-low segment pattern to hex nibble, with a hit
// flag for patterns that are not one of the sixteen hex glyphs.
module seg7_pattern_lut
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (seg)
      PAT_0:   nibble = 4'h0;
      PAT_1:   nibble = 4'h1;
      PAT_2:   nibble = 4'h2;
      PAT_3:   nibble = 4'h3;
      PAT_4:   nibble = 4'h4;
      PAT_5:   nibble = 4'h5;
      PAT_6:   nibble = 4'h6;
      PAT_7:   nibble = 4'h7;
      PAT_8:   nibble = 4'h8;
      PAT_9:   nibble = 4'h9;
      PAT_A:   nibble = 4'hA;
      PAT_B:   nibble = 4'hB;
      PAT_C:   nibble = 4'hC;
      PAT_D:   nibble = 4'hD;
      PAT_E:   nibble = 4'hE;
      PAT_F:   nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed seven-segment bus reader: settles each scanned pattern and
// decodes it per digit. Optional decimal point via SEG_SCAN_DP_EN.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    seg_in,
  input  logic [DIGITS-1:0]             an_in,
`ifdef SEG_SCAN_DP_EN
  input  logic                          dp_in,
  output logic [DIGITS-1:0]             dp_out,
`endif
  output logic [4*DIGITS-1:0]           hex_out,
  output logic [DIGITS-1:0]             digit_valid,
  output logic                          upd_pulse,
  output logic [(DIGITS>1 ? $clog2(DIGITS) : 1)-1:0] upd_idx,
  output logic                          pattern_err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEG_SCAN_DP_EN
  localparam int SW = 8 + DIGITS;
`else
  localparam int SW = 7 + DIGITS;
`endif
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]     sample, s_q, s_prev;
  logic [6:0]        held_seg;
  logic [DIGITS-1:0] held_an;
  logic [IW-1:0]     held_idx;
  logic              hit, changed, blank, onehot;
  logic [3:0]        nibble;
  logic [7:0]        cnt;
  state_t            state;

`ifdef SEG_SCAN_DP_EN
  logic held_dp;
  assign sample  = {dp_in, an_in, seg_in};
  assign held_dp = s_prev[SW-1];
`else
  assign sample  = {an_in, seg_in};
`endif

  // The commit decodes s_prev: it is the last sample of the stable window,
  // so an input change arriving during COMMIT cannot corrupt the write.
  assign held_seg = s_prev[6:0];
  assign held_an  = s_prev[7 +: DIGITS];
  assign changed  = (s_q != s_prev);
  assign blank    = &held_an;
  assign onehot   = $onehot(~held_an);

  always_comb begin
    held_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!held_an[i]) held_idx = IW'(i);
  end

  seg7_pattern_lut u_lut (
    .seg    (held_seg),
    .hit    (hit),
    .nibble (nibble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '1;
      s_prev      <= '1;
      cnt         <= '0;
      state       <= SETTLE;
      hex_out     <= '0;
      digit_valid <= '0;
      upd_pulse   <= 1'b0;
      upd_idx     <= '0;
      pattern_err <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_out      <= '0;
`endif
    end else begin
      s_q         <= sample;
      s_prev      <= s_q;
      upd_pulse   <= 1'b0;
      pattern_err <= 1'b0;
      case (state)
        SETTLE: begin
          if (changed) cnt <= '0;
          else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == CNT_LAST) state <= COMMIT;
          end
        end
        COMMIT: begin
          if (!blank) begin
            if (!onehot) pattern_err <= 1'b1;
            else if (hit) begin
              hex_out[{held_idx, 2'b00} +: 4] <= nibble;
              digit_valid[held_idx]           <= 1'b1;
              upd_pulse                       <= 1'b1;
              upd_idx                         <= held_idx;
`ifdef SEG_SCAN_DP_EN
              dp_out[held_idx]                <= ~held_dp;
`endif
            end else begin
              digit_valid[held_idx] <= 1'b0;
              pattern_err           <= 1'b1;
            end
          end
          cnt   <= '0;
          state <= changed ? SETTLE : HOLD;
        end
        HOLD: begin
          if (changed) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected commit
// events, a negedge monitor pops and compares them against every pulse.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic        upd_pulse;
  logic [1:0]  upd_idx;
  logic        pattern_err;
`ifdef SEG_SCAN_DP_EN
  logic        dp_in;
  logic [3:0]  dp_out;
`endif

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
`ifdef SEG_SCAN_DP_EN
    .dp_in       (dp_in),
    .dp_out      (dp_out),
`endif
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .upd_pulse   (upd_pulse),
    .upd_idx     (upd_idx),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [1:0]  idx;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  dp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [1:0] idx, input logic [15:0] hex,
                           input logic [3:0] v, input logic [3:0] dp);
    exp_t e;
    e.err = err; e.idx = idx; e.hex = hex; e.valid = v; e.dp = dp;
    sb.push_back(e);
  endtask

  // Drive starting #1 after an edge, hold for n edges, return #1 after the last.
  task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (upd_pulse || pattern_err)) begin
      check("pulse_exclusive", 32'(upd_pulse & pattern_err), 32'd0);
      if (sb.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("event_kind", 32'(pattern_err), 32'(e.err));
        check("event_idx", 32'(upd_idx), 32'(e.idx));
        check("event_hex", 32'(hex_out), 32'(e.hex));
        check("event_valid", 32'(digit_valid), 32'(e.valid));
`ifdef SEG_SCAN_DP_EN
        check("event_dp", 32'(dp_out), 32'(e.dp));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; seg_in = 7'h7F; an_in = 4'hF;
`ifdef SEG_SCAN_DP_EN
    dp_in = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 32'(hex_out), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_upd", 32'(upd_pulse), 32'h0);
    check("rst_err", 32'(pattern_err), 32'h0);
    check("rst_idx", 32'(upd_idx), 32'h0);
`ifdef SEG_SCAN_DP_EN
    check("rst_dp", 32'(dp_out), 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single digit '3' on position 1, with exact commit latency.
    expect_ev(1'b0, 2'd1, 16'h0030, 4'b0010, 4'h0);
    drive(7'h30, 4'b1101, 5);
    check("latency_early", 32'(upd_pulse), 32'd0);
    drive(7'h30, 4'b1101, 1);
    check("latency_pulse", 32'(upd_pulse), 32'd1);
    check("t1_hex", 32'(hex_out), 32'h0030);

    // Full scan 1,2,A,F.
    expect_ev(1'b0, 2'd0, 16'h0031, 4'b0011, 4'h0);
    expect_ev(1'b0, 2'd1, 16'h0021, 4'b0011, 4'h0);
    expect_ev(1'b0, 2'd2, 16'h0A21, 4'b0111, 4'h0);
    expect_ev(1'b0, 2'd3, 16'hFA21, 4'b1111, 4'h0);
    drive(7'h79, 4'b1110, 5);
    drive(7'h24, 4'b1101, 5);
    drive(7'h08, 4'b1011, 5);
    drive(7'h0E, 4'b0111, 5);
    drive(7'h7F, 4'b1111, 6);
    check("scan_hex", 32'(hex_out), 32'hFA21);
    check("scan_valid", 32'(digit_valid), 32'hF);

    // Digit 0 shows 2, then an unknown pattern invalidates it.
    expect_ev(1'b0, 2'd0, 16'hFA22, 4'b1111, 4'h0);
    expect_ev(1'b1, 2'd0, 16'hFA22, 4'b1110, 4'h0);
    drive(7'h24, 4'b1110, 6);
    drive(7'h7F, 4'b1110, 6);
    check("miss_valid", 32'(digit_valid), 32'hE);
    check("miss_hex", 32'(hex_out), 32'hFA22);

    // Two anodes low -> error; all high -> silent blanking.
    expect_ev(1'b1, 2'd0, 16'hFA22, 4'b1110, 4'h0);
    drive(7'h40, 4'b1100, 6);
    drive(7'h7F, 4'b1111, 6);
    check("anode_hex", 32'(hex_out), 32'hFA22);
    check("anode_valid", 32'(digit_valid), 32'hE);

    // Windows of 3 cycles never settle.
    for (int i = 0; i < 4; i++) begin
      drive(7'h79, 4'b1011, 3);
      drive(7'h24, 4'b1011, 3);
    end
    drive(7'h7F, 4'b1111, 6);
    check("toggle_hex", 32'(hex_out), 32'hFA22);
    check("toggle_valid", 32'(digit_valid), 32'hE);

    // Reset asserted in the COMMIT cycle, then a full window after release.
    drive(7'h30, 4'b0111, 5);
    rst = 1'b1;
    #1;
    check("rstc_hex", 32'(hex_out), 32'h0);
    check("rstc_valid", 32'(digit_valid), 32'h0);
    check("rstc_idx", 32'(upd_idx), 32'h0);
    check("rstc_pulses", 32'({upd_pulse, pattern_err}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_ev(1'b0, 2'd3, 16'h3000, 4'b1000, 4'h0);
    drive(7'h30, 4'b0111, 5);
    check("rel_early", 32'(upd_pulse), 32'd0);
    drive(7'h30, 4'b0111, 1);
    check("rel_pulse", 32'(upd_pulse), 32'd1);
    drive(7'h7F, 4'b1111, 6);

`ifdef SEG_SCAN_DP_EN
    expect_ev(1'b0, 2'd2, 16'h3800, 4'b1100, 4'b0100);
    dp_in = 1'b0;
    drive(7'h00, 4'b1011, 6);
    dp_in = 1'b1;
    drive(7'h7F, 4'b1111, 6);
    check("dp_out", 32'(dp_out), 32'h4);
    check("dp_hex", 32'(hex_out[11:8]), 32'h8);
`endif

    drive(7'h7F, 4'b1111, 8);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
